// File: rtl/sub_arbiter.sv
// Round-robin arbiter that time-shares one combinational subtractor between
// NREQ requesters. The winner's operands are registered onto the subtractor
// inputs. The difference and zero flag are captured one cycle later and
// returned, tagged with the owner's ID, over a valid/ready handshake.
module sub_arbiter #(
    parameter int unsigned   WIDTH = 32,
    parameter int unsigned   NREQ  = 4,
    localparam int unsigned  IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      sub_inA,
    output logic [WIDTH-1:0]      sub_inB,
    input  logic [WIDTH-1:0]      sub_out,
    input  logic                  sub_flag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_zero,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  ina_q, ina_d;
    logic [WIDTH-1:0]  inb_q, inb_d;
    logic              valid_q, valid_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              zero_q, zero_d;
    logic              busy_q;

    logic              found;
    logic [IDW-1:0]    win_idx;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;

    // Round-robin search starting at rr_q; IDW-bit addition wraps since NREQ is a power of two.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[rr_q + IDW'(k)]) begin
                found   = 1'b1;
                win_idx = rr_q + IDW'(k);
            end
        end
    end

    // Select the winner's operand pair with constant part-selects.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_idx) begin
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: issue from IDLE or from an accepted DONE, capture in EXEC.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        ina_d   = ina_q;
        inb_d   = inb_q;
        valid_d = valid_q;
        id_d    = id_q;
        data_d  = data_q;
        zero_d  = zero_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d        = StExec;
                    gnt_d[win_idx] = 1'b1;
                    ina_d          = win_a;
                    inb_d          = win_b;
                    owner_d        = win_idx;
                    rr_d           = win_idx + IDW'(1);
                end
            end
            StExec: begin
                state_d = StDone;
                valid_d = 1'b1;
                id_d    = owner_q;
                data_d  = sub_out;
                zero_d  = sub_flag;
            end
            StDone: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    if (found) begin
                        state_d        = StExec;
                        gnt_d[win_idx] = 1'b1;
                        ina_d          = win_a;
                        inb_d          = win_b;
                        owner_d        = win_idx;
                        rr_d           = win_idx + IDW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ina_q   <= '0;
            inb_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign gnt       = gnt_q;
    assign sub_inA   = ina_q;
    assign sub_inB   = inb_q;
    assign res_valid = valid_q;
    assign res_id    = id_q;
    assign res_data  = data_q;
    assign res_zero  = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter with a behavioural shared subtractor.
module tb_sub_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      sub_inA;
    logic [WIDTH-1:0]      sub_inB;
    logic [WIDTH-1:0]      sub_out;
    logic                  sub_flag;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_data;
    logic                  res_zero;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared subtractor the arbiter fronts.
    assign sub_out  = sub_inA - sub_inB;
    assign sub_flag = (sub_out == '0);

    sub_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_a    (req_a),
        .req_b    (req_b),
        .gnt      (gnt),
        .sub_inA  (sub_inA),
        .sub_inB  (sub_inB),
        .sub_out  (sub_out),
        .sub_flag (sub_flag),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_data (res_data),
        .res_zero (res_zero),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_inA", sub_inA, 0);
        check("rst_inB", sub_inB, 0);
        check("rst_valid", res_valid, 0);
        check("rst_id", res_id, 0);
        check("rst_data", res_data, 0);
        check("rst_zero", res_zero, 0);
        check("rst_busy", busy, 0);

        // Single op: 10 - 3
        set_op(0, 10, 3);
        req = 4'b0001;
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_inA", sub_inA, 10);
        check("t1_inB", sub_inB, 3);
        check("t1_busy", busy, 1);
        check("t1_valid0", res_valid, 0);
        req = '0;
        tick();
        check("t1_gnt_off", gnt, 0);
        check("t1_valid", res_valid, 1);
        check("t1_id", res_id, 0);
        check("t1_data", res_data, 7);
        check("t1_zero", res_zero, 0);
        tick();
        check("t1_idle_valid", res_valid, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_inA_hold", sub_inA, 10);

        // All requesting, equal operands: strict rotation every 2 cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 5, 5);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("rot_gnt", gnt, 4'b0001 << (n % 4));
            check("rot_valid_lo", res_valid, 0);
            tick();
            check("rot_gnt_off", gnt, 0);
            check("rot_valid", res_valid, 1);
            check("rot_id", res_id, n % 4);
            check("rot_data", res_data, 0);
            check("rot_zero", res_zero, 1);
        end
        req = '0;
        tick();
        check("rot_idle", busy, 0);

        // Wrap-around: 0 - 1 from requester 2 (rr = 1)
        set_op(2, 0, 1);
        req = 4'b0100;
        tick();
        check("wrap_gnt", gnt, 4'b0100);
        req = '0;
        tick();
        check("wrap_data", res_data, 32'hFFFF_FFFF);
        check("wrap_zero", res_zero, 0);
        check("wrap_id", res_id, 2);

        // Back-pressure: result held, req1 waits
        res_ready = 1'b0;
        set_op(1, 100, 1);
        req = 4'b0010;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 32'hFFFF_FFFF);
            check("bp_gnt", gnt, 0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_gnt_go", gnt, 4'b0010);
        check("bp_valid_lo", res_valid, 0);
        req = '0;
        tick();
        check("bp_valid2", res_valid, 1);
        check("bp_data2", res_data, 99);
        check("bp_id2", res_id, 1);
        tick();
        check("bp_idle", busy, 0);

        // Reset during EXEC discards the operation
        set_op(0, 10, 3);
        req = 4'b0001;
        tick();
        check("rx_gnt", gnt, 4'b0001);
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        check("rx_gnt0", gnt, 0);
        check("rx_inA0", sub_inA, 0);
        check("rx_inB0", sub_inB, 0);
        check("rx_valid0", res_valid, 0);
        check("rx_busy0", busy, 0);
        tick();
        check("rx_noresult", res_valid, 0);
        set_op(3, 20, 5);
        req = 4'b1000;
        tick();
        check("rx_gnt3", gnt, 4'b1000);
        req = '0;
        tick();
        check("rx_data3", res_data, 15);
        check("rx_id3", res_id, 3);
        tick();

        // Fairness: req 0101 held, second grant goes to 2 (rr = 0 here)
        set_op(0, 9, 4);
        set_op(2, 0, 1);
        req = 4'b0101;
        tick();
        check("fair_gnt0", gnt, 4'b0001);
        tick();
        check("fair_id0", res_id, 0);
        check("fair_data0", res_data, 5);
        tick();
        check("fair_gnt2", gnt, 4'b0100);
        tick();
        check("fair_id2", res_id, 2);
        check("fair_data2", res_data, 32'hFFFF_FFFF);
        req = '0;
        tick();
        check("fair_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 32-bit subtract/zero-flag unit (inputs inA/inB, outputs difference and zero flag) between NREQ requesters.
- Registers the winning operand pair onto the shared unit's inputs and captures its difference and zero flag one cycle later.
- Returns the result, tagged with the requester ID, over a valid/ready handshake.
- Sits between the ALU's client blocks and the single subtractor instance.

Parameters:
- WIDTH, 32, operand/result width; must match the shared subtractor.
- NREQ, 4, number of requesters; power of two, 2..8.
- IDW, $clog2(NREQ), requester-ID width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; held with operands until granted
- req_a  input  NREQ*WIDTH  packed minuends; requester i at [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  packed subtrahends; same packing
- gnt  output  NREQ  one-hot, one-cycle grant pulse
- sub_inA  output  WIDTH  registered minuend to shared subtractor
- sub_inB  output  WIDTH  registered subtrahend to shared subtractor
- sub_out  input  WIDTH  difference from shared subtractor (combinational)
- sub_flag  input  1  zero flag from shared subtractor (1 when difference == 0)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_id  output  IDW  index of requester that owns the result
- res_data  output  WIDTH  captured difference, modulo 2^WIDTH
- res_zero  output  1  captured zero flag
- busy  output  1  high in EXEC or DONE

Behaviour:
- Reset (rst high at an edge, takes priority over everything):
  - state = IDLE; rr pointer = 0.
  - gnt = 0, sub_inA = 0, sub_inB = 0.
  - res_valid = 0, res_id = 0, res_data = 0, res_zero = 0, busy = 0.
  - Any in-flight operation is discarded; no result is produced for it.
- FSM states: IDLE, EXEC, DONE.
- Arbitration runs only when the FSM can issue: in IDLE, or in DONE with res_ready = 1.
  - Winner = first i with req[i] = 1, searching from index rr upward and wrapping modulo NREQ.
  - On the issuing edge: sub_inA/sub_inB <= winner's operands; gnt <= one-hot(winner); rr <= (winner+1) mod NREQ; state <= EXEC.
  - No request pending: gnt <= 0 and state unchanged (IDLE) or IDLE (from DONE).
- gnt is high exactly one cycle, the cycle after the issuing edge.
  - The requester may drop req or change operands from the next edge onward.
  - req is not sampled in EXEC or in DONE without res_ready.
- EXEC, on the next edge:
  - res_data <= sub_out; res_zero <= sub_flag; res_id <= winner; res_valid <= 1.
  - gnt <= 0; state <= DONE.
- DONE:
  - res_valid, res_id, res_data and res_zero hold stable while res_ready = 0.
  - On an edge with res_ready = 1: res_valid <= 0 and return to IDLE, or issue again in the same edge (DONE -> EXEC) if any req is pending.
  - If a new issue occurs in that edge, res_valid goes low that edge and rises again one edge later.
- Latency: the issuing edge is k; res_valid = 1 after edge k+1. Peak throughput is one operation per 2 cycles.
- sub_inA/sub_inB hold their last issued values until the next issue; they are not cleared on completion.
- Arithmetic: wrap-around difference. No borrow or overflow output. res_zero is passed through unaltered from sub_flag.
- busy = (state != IDLE), registered with the state.
- Boundaries:
  - req high on all lines: strict rotation 0,1,2,3,0,...
  - Single requester asserting continuously: served every 2 cycles when res_ready is held 1.
  - req asserted during EXEC: waits, no loss.
  - req withdrawn before issue: never granted.

Test Plan:
- Reset, then req=0001, a0=10, b0=3, res_ready=1 -> gnt=0001 for one cycle; next cycle res_valid=1, res_id=0, res_data=7, res_zero=0; then IDLE, busy=0.
- req=1111 held, res_ready=1, all a=b=5 -> grants 0001,0010,0100,1000,0001 spaced 2 cycles apart; every result has res_data=0, res_zero=1, and ids 0,1,2,3,0.
- a2=0, b2=1 -> res_data=0xFFFFFFFF, res_zero=0, res_id=2.
- Result pending, res_ready=0 for 5 cycles with req1 asserted -> res_valid/res_data stable, no gnt; when res_ready=1, gnt=0010 next cycle and the new result follows one cycle later.
- rst asserted during EXEC -> next cycle all outputs 0, state IDLE; the following request from requester 3 (rr=0, req=1000) is granted requester 3.
- req=0101, res_ready=1, after first grant to 0 -> next grant goes to 2 even though req0 is still high.
